read_mem: RTL and testbench



---
 rtl/read_mem_pkg.sv | 15 +
 rtl/read_mem_fifo.sv | 44 ++++
 rtl/read_mem.sv | 118 +++++++++++
 tb/tb_read_mem.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_mem_pkg.sv
// read_mem_pkg: shared types and sizing for the read_mem stream readout block
package read_mem_pkg;

    typedef enum logic [1:0] {
        INIT_ST,
        READ_ST,
        DRAIN_ST,
        END_ST
    } state_t;

    function automatic int fifo_depth(input int lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/read_mem_fifo.sv
// read_mem_fifo: synchronous FIFO holding stream beats (data plus last flag)
module read_mem_fifo #(
    parameter int W = 17,
    parameter int D = 4,
    localparam int CW = $clog2(D + 1),
    localparam int PW = $clog2(D)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [D];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full = count == CW'(D);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = empty ? '0 : mem[rd_ptr];

    // beat storage, written at the tail
    always_ff @(posedge aclk)
        if (do_push) mem[wr_ptr] <= din;

    // ring pointers and occupancy
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == PW'(D - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == PW'(D - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end

endmodule

// File: rtl/read_mem.sv
// read_mem: reads a block of words from a dual-port memory and streams it out
// over AXI4-Stream; optional status outputs with READ_MEM_STATUS_EN
module read_mem
    import read_mem_pkg::*;
#(
    parameter int N = 8,
    parameter int B = 16,
    parameter int LAT = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    output logic [N-1:0] mem_addr,
    input  logic [B-1:0] mem_do,
    output logic [B-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    input  logic         START_REG,
    input  logic [N-1:0] ADDR_REG,
    input  logic [N-1:0] NSAMP_REG
`ifdef READ_MEM_STATUS_EN
    ,
    output logic         BUSY_REG,
    output logic [N-1:0] NSENT_REG
`endif
);
    localparam int D = fifo_depth(LAT);
    localparam int CW = $clog2(D + 1);

    state_t state;
    logic [N-1:0] addr_r, cnt_r;
    logic [LAT-1:0] vld_p, last_p;
    logic abort_r;
    logic [CW-1:0] fifo_cnt;
    logic fifo_full, fifo_empty, fifo_last;
    logic issue, pop, aborting;
    int inflight;

    // credit check: a read may only issue if its word is guaranteed a FIFO slot
    always_comb begin
        inflight = $countones(vld_p);
        issue = state == READ_ST && START_REG && !fifo_full && int'(fifo_cnt) + inflight < D;
        aborting = abort_r || (state == READ_ST && !START_REG);
        pop = m_axis_tvalid && m_axis_tready;
    end

    assign mem_addr = addr_r;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast = fifo_last || (aborting && fifo_cnt == CW'(1) && inflight == 0);

    // block sequencer: latches the request, issues reads, waits for drain
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state <= INIT_ST;
            addr_r <= '0;
            cnt_r <= '0;
            abort_r <= 1'b0;
        end else begin
            case (state)
                INIT_ST:
                    if (START_REG) begin
                        addr_r <= ADDR_REG;
                        cnt_r <= NSAMP_REG;
                        abort_r <= 1'b0;
                        state <= NSAMP_REG != '0 ? READ_ST : END_ST;
                    end
                READ_ST:
                    if (!START_REG) begin
                        abort_r <= 1'b1;
                        state <= DRAIN_ST;
                    end else if (issue) begin
                        addr_r <= addr_r + 1'b1;
                        cnt_r <= cnt_r - 1'b1;
                        if (cnt_r == N'(1)) state <= DRAIN_ST;
                    end
                DRAIN_ST: if (inflight == 0 && fifo_empty) state <= END_ST;
                END_ST: if (!START_REG) state <= INIT_ST;
                default: state <= INIT_ST;
            endcase
        end

    // valid/last tags travel alongside the read so they line up with mem_do
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            vld_p <= '0;
            last_p <= '0;
        end else begin
            vld_p[0] <= issue;
            last_p[0] <= issue && cnt_r == N'(1);
            for (int i = 1; i < LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end

    read_mem_fifo #(.W(B + 1), .D(D)) u_fifo (
        .aclk   (aclk),
        .aresetn(aresetn),
        .push   (vld_p[LAT-1]),
        .din    ({last_p[LAT-1], mem_do}),
        .pop    (pop),
        .dout   ({fifo_last, m_axis_tdata}),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

`ifdef READ_MEM_STATUS_EN
    assign BUSY_REG = state == READ_ST || state == DRAIN_ST;

    // accepted-beat counter for the current block
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) NSENT_REG <= '0;
        else if (state == INIT_ST && START_REG && NSAMP_REG != '0) NSENT_REG <= '0;
        else if (pop) NSENT_REG <= NSENT_REG + 1'b1;
`endif

endmodule

// File: tb/tb_read_mem.sv
// tb_read_mem: randomized self-checking bench for read_mem
module tb_read_mem;
    import read_mem_pkg::*;

    localparam int N = 8;
    localparam int B = 16;
    localparam int LAT = 2;
    localparam int D = LAT + 2;
    localparam int DEPTH = 1 << N;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [N-1:0] mem_addr;
    logic [B-1:0] mem_do;
    logic [B-1:0] m_axis_tdata;
    logic m_axis_tvalid;
    logic m_axis_tready = 1'b0;
    logic m_axis_tlast;
    logic START_REG = 1'b0;
    logic [N-1:0] ADDR_REG = '0;
    logic [N-1:0] NSAMP_REG = '0;
`ifdef READ_MEM_STATUS_EN
    logic BUSY_REG;
    logic [N-1:0] NSENT_REG;
`endif

    read_mem #(.N(N), .B(B), .LAT(LAT)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .mem_addr     (mem_addr),
        .mem_do       (mem_do),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .START_REG    (START_REG),
        .ADDR_REG     (ADDR_REG),
        .NSAMP_REG    (NSAMP_REG)
`ifdef READ_MEM_STATUS_EN
        ,
        .BUSY_REG     (BUSY_REG),
        .NSENT_REG    (NSENT_REG)
`endif
    );

    always #5 aclk = ~aclk;

    // memory with LAT cycles of read latency
    logic [B-1:0] mem [DEPTH];
    logic [N-1:0] apipe [LAT];
    always @(posedge aclk) begin
        apipe[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_do = mem[apipe[LAT-1]];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc, first_v, unstable, ovf;
    logic start_v = 1'b0;
    logic hold;
    logic [B:0] hold_val;
    logic [B-1:0] got_d[$];
    logic got_l[$];
    int got_c[$];
    logic [B-1:0] exp_d[$];
    logic exp_l[$];

    task automatic clear();
        got_d.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_l.delete();
        cyc = 0; first_v = -1; unstable = 0; ovf = 0; hold = 1'b0;
    endtask

    // reference: n consecutive words from addr, wrapping modulo the memory size
    task automatic model(input int addr, input int n);
        for (int k = 0; k < n; k++) begin
            exp_d.push_back(mem[(addr + k) % DEPTH]);
            exp_l.push_back(k == n - 1);
        end
    endtask

    // one clock: drive START/tready after the edge, then observe the stream
    task automatic tick(input int pct);
        logic rdy;
        @(posedge aclk);
        #1;
        rdy = $urandom_range(99) < pct;
        START_REG = start_v;
        m_axis_tready = rdy;
        cyc++;
        #1;
        if (hold && !(m_axis_tvalid && {m_axis_tlast, m_axis_tdata} == hold_val)) unstable++;
        if (m_axis_tvalid && first_v < 0) first_v = cyc;
        if (int'(dut.u_fifo.count) > D) ovf++;
        if (m_axis_tvalid && rdy) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
            got_c.push_back(cyc);
        end
        hold = m_axis_tvalid && !rdy;
        hold_val = {m_axis_tlast, m_axis_tdata};
    endtask

    task automatic go_idle();
        start_v = 1'b0;
        for (int i = 0; i < 6; i++) tick(100);
    endtask

    task automatic check_stream(input string name);
        tests_run++;
        if (got_d.size() !== exp_d.size()) begin
            tests_failed++;
            $display("FAIL %s beats: got %0d expected %0d", name, got_d.size(), exp_d.size());
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            tests_run++;
            if ({got_l[i], got_d[i]} !== {exp_l[i], exp_d[i]}) begin
                tests_failed++;
                $display("FAIL %s beat %0d: got last=%0b data=%0h expected last=%0b data=%0h",
                         name, i, got_l[i], got_d[i], exp_l[i], exp_d[i]);
            end
        end
        tests_run++;
        if (unstable !== 0 || ovf !== 0) begin
            tests_failed++;
            $display("FAIL %s axis stability/overflow: got %0d/%0d events expected 0/0", name, unstable, ovf);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        tests_run++;
        if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset valid/last: got %b expected 00", {m_axis_tvalid, m_axis_tlast});
        end
        tests_run++;
        if (m_axis_tdata !== '0 || mem_addr !== '0) begin
            tests_failed++;
            $display("FAIL reset data/addr: got %0h/%0h expected 0/0", m_axis_tdata, mem_addr);
        end
        tests_run++;
        if (dut.state !== INIT_ST) begin
            tests_failed++;
            $display("FAIL reset state: got %0d expected %0d", dut.state, INIT_ST);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < DEPTH; i++) mem[i] = B'(i);
        clear();
        ADDR_REG = 0; NSAMP_REG = 10; start_v = 1'b1;
        model(0, 10);
        for (int i = 0; i < 40; i++) tick(100);
        check_stream("basic");
        tests_run++;
        if (first_v - 1 !== LAT + 2) begin
            tests_failed++;
            $display("FAIL basic latency: got %0d expected %0d", first_v - 1, LAT + 2);
        end
        tests_run++;
        if (got_c.size() != 10 || got_c[got_c.size()-1] - got_c[0] !== 9) begin
            tests_failed++;
            $display("FAIL basic gapless: got %0d beats, span %0d expected 10 beats, span 9",
                     got_c.size(), got_c.size() > 0 ? got_c[got_c.size()-1] - got_c[0] : -1);
        end
        go_idle();
    endtask

    task automatic test_wrap();
        clear();
        ADDR_REG = 250; NSAMP_REG = 10; start_v = 1'b1;
        model(250, 10);
        for (int i = 0; i < 40; i++) tick(100);
        check_stream("wrap");
        go_idle();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < DEPTH; i++) mem[i] = B'($urandom);
        clear();
        ADDR_REG = N'($urandom); NSAMP_REG = 20; start_v = 1'b1;
        model(int'(ADDR_REG), 20);
        for (int i = 0; i < 150; i++) tick(50);
        check_stream("backpressure");
        go_idle();
    endtask

    task automatic test_random_blocks();
        for (int r = 0; r < 4; r++) begin
            int a, n, p;
            a = $urandom_range(DEPTH - 1);
            n = $urandom_range(40, 1);
            p = $urandom_range(100, 30);
            clear();
            ADDR_REG = N'(a); NSAMP_REG = N'(n); start_v = 1'b1;
            model(a, n);
            for (int i = 0; i < n * 8 + 40; i++) tick(p);
            check_stream($sformatf("random%0d", r));
            go_idle();
        end
    endtask

    task automatic test_zero_length();
        clear();
        ADDR_REG = 5; NSAMP_REG = 0; start_v = 1'b1;
        for (int i = 0; i < 15; i++) tick(100);
        tests_run++;
        if (first_v !== -1) begin
            tests_failed++;
            $display("FAIL zero tvalid: got first valid at cycle %0d expected never", first_v);
        end
        tests_run++;
        if (dut.state !== END_ST) begin
            tests_failed++;
            $display("FAIL zero end state: got %0d expected %0d", dut.state, END_ST);
        end
        go_idle();
        tests_run++;
        if (dut.state !== INIT_ST) begin
            tests_failed++;
            $display("FAIL zero init state: got %0d expected %0d", dut.state, INIT_ST);
        end
    endtask

    task automatic test_abort();
        int k;
        for (int i = 0; i < DEPTH; i++) mem[i] = B'(i);
        clear();
        ADDR_REG = 0; NSAMP_REG = 100; start_v = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick(100);
            if (got_d.size() >= 30) start_v = 1'b0;
        end
        k = got_d.size();
        tests_run++;
        if (k < 31 || k > 30 + D) begin
            tests_failed++;
            $display("FAIL abort beats: got %0d expected 31..%0d", k, 30 + D);
        end
        model(0, k);
        check_stream("abort");
        go_idle();
        clear();
        ADDR_REG = 7; NSAMP_REG = 5; start_v = 1'b1;
        model(7, 5);
        for (int i = 0; i < 30; i++) tick(100);
        check_stream("rearm");
        go_idle();
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < DEPTH; i++) mem[i] = B'($urandom);
        clear();
        ADDR_REG = 100; NSAMP_REG = 50; start_v = 1'b1;
        for (int i = 0; i < 40 && got_d.size() < 5; i++) tick(100);
        aresetn = 1'b0;
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL async reset valid/last: got %b%b expected 00", m_axis_tvalid, m_axis_tlast);
        end
        start_v = 1'b0;
        START_REG = 1'b0;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        clear();
        ADDR_REG = 20; NSAMP_REG = 6; start_v = 1'b1;
        model(20, 6);
        for (int i = 0; i < 30; i++) tick(100);
        check_stream("after_reset");
        go_idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_random_blocks();
        test_zero_length();
        test_abort();
        test_reset_mid_block();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
